// File: rtl/prog_priority_arbiter_pkg.sv
// Shared state types, reset constant and cyclic search helper for the
// programmable-priority arbiter.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
    typedef enum logic {CFG_IDLE, CFG_ACK}   cfg_state_t;

    // Priority loaded into every table entry on reset.
    localparam int unsigned PRIO_RESET = 0;

    // Widest request vector the search helper handles (NUM_REQ <= 64).
    localparam int unsigned SEARCH_MAX = 64;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } search_t;

    // First set bit of vec[n-1:0] at or after ptr, wrapping past n-1 to 0.
    function automatic search_t first_set_from(
        input logic [SEARCH_MAX-1:0] vec,
        input logic [5:0]            ptr,
        input int unsigned           n
    );
        search_t     res;
        int unsigned pos;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned k = 0; k < SEARCH_MAX; k++) begin
            if (k < n) begin
                pos = 32'(ptr) + k;
                if (pos >= n) begin
                    pos = pos - n;
                end
                if (!res.found && vec[pos[5:0]]) begin
                    res.found = 1'b1;
                    res.idx   = pos[5:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prog_priority_arbiter_prio_table.sv
// Priority register file with its valid/ready config port. Writes commit on
// the accepting edge; the response (ready/rdata/err) follows one cycle later.
module prio_table
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 16,
    parameter int unsigned PRIO_WIDTH = 4,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    input  logic                          cfg_wr_rd,
    input  logic [IDX_WIDTH-1:0]          cfg_addr,
    input  logic [PRIO_WIDTH-1:0]         cfg_wdata,
    output logic [PRIO_WIDTH-1:0]         cfg_rdata,
    output logic                          cfg_ready,
    output logic                          cfg_err,
    output logic [NUM_REQ*PRIO_WIDTH-1:0] prio_flat
);

    logic [NUM_REQ-1:0][PRIO_WIDTH-1:0] prio_mem;
    cfg_state_t                         cfg_state;
    logic                               addr_bad;

    assign prio_flat = prio_mem;

    // Flag addresses beyond the last requester (reachable when NUM_REQ is not a power of two).
    always_comb begin
        addr_bad = (32'(cfg_addr) >= NUM_REQ);
    end

    // Config FSM: accept in CFG_IDLE, pulse the registered response in CFG_ACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_state <= CFG_IDLE;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_rdata <= '0;
            prio_mem  <= {NUM_REQ{PRIO_WIDTH'(PRIO_RESET)}};
        end else begin
            case (cfg_state)
                CFG_IDLE: begin
                    cfg_ready <= 1'b0;
                    cfg_err   <= 1'b0;
                    cfg_rdata <= '0;
                    if (cfg_valid) begin
                        cfg_state <= CFG_ACK;
                        cfg_ready <= 1'b1;
                        cfg_err   <= addr_bad;
                        if (!addr_bad) begin
                            if (cfg_wr_rd) begin
                                prio_mem[cfg_addr] <= cfg_wdata;
                            end else begin
                                cfg_rdata <= prio_mem[cfg_addr];
                            end
                        end
                    end
                end
                CFG_ACK: begin
                    cfg_state <= CFG_IDLE;
                    cfg_ready <= 1'b0;
                    cfg_err   <= 1'b0;
                    cfg_rdata <= '0;
                end
                default: begin
                    cfg_state <= CFG_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_priority_arbiter.sv
// Programmable-priority arbiter: highest table priority wins, ties resolved
// round-robin from rr_ptr, grant held until release or hold timeout.
module prog_priority_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 16,
    parameter int unsigned PRIO_WIDTH = 4,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ),
    parameter int unsigned MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [IDX_WIDTH-1:0]  gnt_idx,
    output logic                  gnt_valid,
    input  logic                  cfg_valid,
    input  logic                  cfg_wr_rd,
    input  logic [IDX_WIDTH-1:0]  cfg_addr,
    input  logic [PRIO_WIDTH-1:0] cfg_wdata,
    output logic [PRIO_WIDTH-1:0] cfg_rdata,
    output logic                  cfg_ready,
    output logic                  cfg_err
);

    localparam int unsigned          HOLD_W     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]    HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(NUM_REQ - 1);

    logic [NUM_REQ*PRIO_WIDTH-1:0]      prio_flat;
    logic [NUM_REQ-1:0][PRIO_WIDTH-1:0] prio_vec;

    arb_state_t                         arb_state;
    logic [IDX_WIDTH-1:0]               rr_ptr;
    logic [HOLD_W-1:0]                  hold_cnt;

    logic [NUM_REQ-1:0]                 eligible;
    logic [NUM_REQ-1:0]                 tied;
    logic [PRIO_WIDTH-1:0]              max_prio;
    logic                               owner_req;
    logic                               others_pending;
    logic                               timeout;
    logic                               rearb;
    logic                               win_found;
    logic [IDX_WIDTH-1:0]               win_idx;
    search_t                            search;

    prio_table #(
        .NUM_REQ    (NUM_REQ),
        .PRIO_WIDTH (PRIO_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_prio_table (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_wr_rd (cfg_wr_rd),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .prio_flat (prio_flat)
    );

    assign prio_vec = prio_flat;

    // Winner among requesters other than the current owner: max priority, then round-robin.
    always_comb begin
        owner_req      = |(req & gnt);
        others_pending = |(req & ~gnt);
        timeout        = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT) && others_pending;
        rearb          = (arb_state == ARB_IDLE) || !owner_req || timeout;
        // gnt is zero when idle, so masking the owner serves every decision.
        eligible       = req & ~gnt;
        max_prio       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (eligible[i] && (prio_vec[i] > max_prio)) begin
                max_prio = prio_vec[i];
            end
        end
        tied = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            tied[i] = eligible[i] && (prio_vec[i] == max_prio);
        end
        search    = first_set_from(SEARCH_MAX'(tied), 6'(rr_ptr), NUM_REQ);
        win_found = search.found;
        win_idx   = IDX_WIDTH'(search.idx);
    end

    // Arbitration FSM with registered grant, round-robin pointer and hold counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_state <= ARB_IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
        end else begin
            case (arb_state)
                ARB_IDLE: begin
                    if (win_found) begin
                        arb_state <= ARB_GRANT;
                        gnt       <= NUM_REQ'(1) << win_idx;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        rr_ptr    <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                        hold_cnt  <= HOLD_W'(1);
                    end
                end
                ARB_GRANT: begin
                    if (!rearb) begin
                        if (hold_cnt < HOLD_LIMIT) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (win_found) begin
                        gnt       <= NUM_REQ'(1) << win_idx;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        rr_ptr    <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                        hold_cnt  <= HOLD_W'(1);
                    end else begin
                        arb_state <= ARB_IDLE;
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end
                end
                default: begin
                    arb_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_priority_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed grant and config responses
// (with the cycle they must appear in); a monitor pops them as the DUT presents them.
module tb_prog_priority_arbiter;

    logic        clk;
    logic        rst;

    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        cfg_valid;
    logic        cfg_wr_rd;
    logic [3:0]  cfg_addr;
    logic [3:0]  cfg_wdata;
    logic [3:0]  cfg_rdata;
    logic        cfg_ready;
    logic        cfg_err;

    logic [11:0] req12;
    logic [11:0] gnt12;
    logic [3:0]  gidx12;
    logic        gval12;
    logic        c12_valid;
    logic        c12_wr;
    logic [3:0]  c12_addr;
    logic [3:0]  c12_wdata;
    logic [3:0]  c12_rdata;
    logic        c12_ready;
    logic        c12_err;

    int total;
    int bad;
    int cyc;

    typedef struct {
        logic [15:0] g;
        int          idx;
        int          at;
    } gexp_t;

    typedef struct {
        int rdata;
        bit err;
        int at;
    } cexp_t;

    gexp_t gq[$];
    cexp_t cq[$];
    cexp_t cq12[$];

    int rr_order[5] = '{0, 1, 2, 3, 0};

    prog_priority_arbiter #(
        .NUM_REQ    (16),
        .PRIO_WIDTH (4),
        .MAX_HOLD   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .cfg_valid (cfg_valid),
        .cfg_wr_rd (cfg_wr_rd),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err)
    );

    prog_priority_arbiter #(
        .NUM_REQ    (12),
        .PRIO_WIDTH (4),
        .MAX_HOLD   (0)
    ) dut12 (
        .clk       (clk),
        .rst       (rst),
        .req       (req12),
        .gnt       (gnt12),
        .gnt_idx   (gidx12),
        .gnt_valid (gval12),
        .cfg_valid (c12_valid),
        .cfg_wr_rd (c12_wr),
        .cfg_addr  (c12_addr),
        .cfg_wdata (c12_wdata),
        .cfg_rdata (c12_rdata),
        .cfg_ready (c12_ready),
        .cfg_err   (c12_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s: DUT output with no expected entry (cycle %0d)", name, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input logic [15:0] g, input int idx, input int dly);
        gexp_t e;
        e.g   = g;
        e.idx = idx;
        e.at  = cyc + dly;
        gq.push_back(e);
    endtask

    // One config transaction on either DUT; response expected one cycle after acceptance.
    task automatic cfg_op(input bit on12, input bit wr, input int addr, input int data,
                          input int exp_rd, input bit exp_err);
        cexp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.at    = cyc + 1;
        if (on12) begin
            c12_valid = 1'b1;
            c12_wr    = wr;
            c12_addr  = 4'(addr);
            c12_wdata = 4'(data);
            cq12.push_back(e);
        end else begin
            cfg_valid = 1'b1;
            cfg_wr_rd = wr;
            cfg_addr  = 4'(addr);
            cfg_wdata = 4'(data);
            cq.push_back(e);
        end
        step(1);
        cfg_valid = 1'b0;
        c12_valid = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic run_monitor();
        logic [15:0] prev_gnt;
        gexp_t       ge;
        cexp_t       ce;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (gnt !== prev_gnt) begin
                if (gq.size() == 0) begin
                    note_fail("gnt_unexpected");
                end else begin
                    ge = gq.pop_front();
                    check("gnt", gnt, ge.g);
                    check("gnt_idx", gnt_idx, ge.idx);
                    check("gnt_valid", gnt_valid, ge.g != 0);
                    check("gnt_cycle", cyc, ge.at);
                end
                prev_gnt = gnt;
            end
            if (cfg_ready === 1'b1) begin
                if (cq.size() == 0) begin
                    note_fail("cfg_unexpected");
                end else begin
                    ce = cq.pop_front();
                    check("cfg_rdata", cfg_rdata, ce.rdata);
                    check("cfg_err", cfg_err, ce.err);
                    check("cfg_cycle", cyc, ce.at);
                end
            end
            if (c12_ready === 1'b1) begin
                if (cq12.size() == 0) begin
                    note_fail("cfg12_unexpected");
                end else begin
                    ce = cq12.pop_front();
                    check("cfg12_rdata", c12_rdata, ce.rdata);
                    check("cfg12_err", c12_err, ce.err);
                    check("cfg12_cycle", cyc, ce.at);
                end
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req       = '0;
        cfg_valid = 1'b0;
        cfg_wr_rd = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        req12     = '0;
        c12_valid = 1'b0;
        c12_wr    = 1'b0;
        c12_addr  = '0;
        c12_wdata = '0;

        fork
            run_monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_gnt", gnt, 16'h0000);
        check("rst_gnt_idx", gnt_idx, 4'h0);
        check("rst_gnt_valid", gnt_valid, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_cfg_rdata", cfg_rdata, 4'h0);
        check("rst_gnt12", gnt12, 12'h000);
        @(posedge clk);
        #1 rst = 1'b1;

        // Reset defaults: all priorities 0, rr_ptr 0.
        req = 16'h0005; expect_gnt(16'h0001, 0, 1);
        step(2);
        req = 16'h0004; expect_gnt(16'h0004, 2, 1);
        step(2);
        req = 16'h0000; expect_gnt(16'h0000, 0, 1);
        step(2);

        // Round-robin over equal priorities; each owner drops its request after 2 cycles.
        do_reset();
        req = 16'h000F; expect_gnt(16'h0001, 0, 1);
        for (int i = 1; i < 5; i++) begin
            step(2);
            req = 16'h000F & ~(16'h0001 << rr_order[i-1]);
            expect_gnt(16'h0001 << rr_order[i], rr_order[i], 1);
            step(1);
            req = 16'h000F;
        end
        step(1);
        req = 16'h0000; expect_gnt(16'h0000, 0, 1);
        step(2);

        // Programming and read-back, including read directly after write.
        cfg_op(0, 1, 7, 9, 0, 0);
        cfg_op(0, 0, 7, 0, 9, 0);
        cfg_op(0, 1, 3, 5, 0, 0);
        cfg_op(0, 0, 3, 0, 5, 0);

        // Priority 9 beats 5; a same-edge write raising prio[3] is not seen and does not pre-empt.
        req = 16'h0088; expect_gnt(16'h0080, 7, 1);
        cfg_op(0, 1, 3, 15, 0, 0);
        req = 16'h0008; expect_gnt(16'h0008, 3, 1);
        step(2);
        req = 16'h0000; expect_gnt(16'h0000, 0, 1);
        step(2);

        // Hold timeout: idx 1 (prio 15) pre-empted by idx 2 (prio 1) after 4 grant cycles.
        cfg_op(0, 1, 1, 15, 0, 0);
        cfg_op(0, 1, 2, 1, 0, 0);
        req = 16'h0006;
        expect_gnt(16'h0002, 1, 1);
        expect_gnt(16'h0004, 2, 5);
        step(6);
        req = 16'h0002; expect_gnt(16'h0002, 1, 1);
        step(12);

        // Async reset mid-grant with a config write pending.
        cfg_valid = 1'b1;
        cfg_wr_rd = 1'b1;
        cfg_addr  = 4'd5;
        cfg_wdata = 4'd7;
        #2;
        rst = 1'b0;
        req = 16'h0000;
        expect_gnt(16'h0000, 0, 0);
        #1;
        check("async_gnt", gnt, 16'h0000);
        check("async_gnt_valid", gnt_valid, 1'b0);
        step(2);
        cfg_valid = 1'b0;
        rst = 1'b1;
        cfg_op(0, 0, 5, 0, 0, 0);
        cfg_op(0, 0, 1, 0, 0, 0);

        // Out-of-range config addresses on the 12-requester instance.
        cfg_op(1, 1, 11, 6, 0, 0);
        cfg_op(1, 1, 13, 9, 0, 1);
        cfg_op(1, 1, 12, 9, 0, 1);
        for (int a = 0; a < 12; a++) begin
            cfg_op(1, 0, a, 0, (a == 11) ? 6 : 0, 0);
        end
        cfg_op(1, 0, 13, 0, 0, 1);

        step(3);
        check("gnt_queue_left", gq.size(), 0);
        check("cfg_queue_left", cq.size(), 0);
        check("cfg12_queue_left", cq12.size(), 0);
        check("gnt12_idle", {gval12, gidx12, gnt12}, 17'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_priority_arbiter.md
Name: prog_priority_arbiter

Overview:
- Parametrised programmable-priority arbiter for NUM_REQ peripheral requesters.
- Contains an internal priority table written and read over a valid/ready config port.
- Issues a registered one-hot grant and its index, held until the owner releases or a hold timeout forces pre-emption.
- Equal priorities are resolved round-robin; sits between peripheral controllers and a shared bus master port.

Parameters:
- NUM_REQ, 16, number of requesters (2..64).
- PRIO_WIDTH, 4, priority field width; larger value = higher priority.
- IDX_WIDTH, $clog2(NUM_REQ), width of index and config address.
- MAX_HOLD, 16, max consecutive grant cycles before pre-emption when others wait; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request vector, bit i = requester i.
- gnt  out  NUM_REQ  one-hot grant, registered.
- gnt_idx  out  IDX_WIDTH  index of current owner; 0 when gnt_valid=0.
- gnt_valid  out  1  a grant is active.
- cfg_valid  in  1  config request; held until cfg_ready.
- cfg_wr_rd  in  1  1 = write, 0 = read.
- cfg_addr  in  IDX_WIDTH  requester index to configure.
- cfg_wdata  in  PRIO_WIDTH  priority to write.
- cfg_rdata  out  PRIO_WIDTH  read data, valid with cfg_ready.
- cfg_ready  out  1  one-cycle completion pulse.
- cfg_err  out  1  with cfg_ready: cfg_addr >= NUM_REQ; no write, rdata=0.

Behaviour:
- Reset (rst=0, async): gnt=0, gnt_idx=0, gnt_valid=0, cfg_rdata=0, cfg_ready=0, cfg_err=0, all table entries 0, rr_ptr=0, hold_cnt=0, both FSMs idle. Reset mid-grant or mid-config aborts immediately with no partial write.
- Config FSM CFG_IDLE/CFG_ACK: in CFG_IDLE with cfg_valid=1, accept the request. A write commits to the table at that clock edge, and the FSM moves to CFG_ACK.
- In CFG_ACK, cfg_ready=1 for exactly one cycle, with cfg_rdata/cfg_err valid, then the FSM returns to CFG_IDLE.
- Latency is 1 cycle from acceptance to ready. Back-to-back requests are spaced 2 cycles apart.
- A read issued right after a write to the same address returns the new value.
- Winner selection (combinational): among eligible requesters, take the highest table value. Ties go to the first tied index at or after rr_ptr, searching cyclically.
- Arbitration uses the table value at the decision edge; a same-cycle config write is not seen.
- Arbitration FSM ARB_IDLE/ARB_GRANT:
  - ARB_IDLE, any req set: register the winner. gnt, gnt_idx and gnt_valid appear the next cycle (1-cycle latency). Go to ARB_GRANT with hold_cnt=1.
  - ARB_GRANT, req[owner]=1, no timeout: hold the grant, hold_cnt++ (saturating at MAX_HOLD).
  - ARB_GRANT, req[owner]=0: re-arbitrate the same edge over the others. If there is a winner, hand over directly with no idle bubble; otherwise gnt=0 and go to ARB_IDLE.
  - Timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD and another requester is pending. Pre-empt to the winner excluding the owner, even if that winner has lower priority. If none is pending, keep holding.
- On every new grant: rr_ptr = owner+1 mod NUM_REQ, hold_cnt=1.
- Priority changes never pre-empt an active grant; they affect the next decision only.
- gnt is always one-hot or zero. gnt_valid == |gnt.

Decomposition:
- Package arb_pkg holds:
  - arb_state_t {ARB_IDLE, ARB_GRANT} and cfg_state_t {CFG_IDLE, CFG_ACK};
  - the reset priority constant PRIO_RESET=0;
  - a function for cyclic first-set-at-or-after-pointer search.
- Sub-module prio_table: the NUM_REQ x PRIO_WIDTH register file, config FSM and error check. It exports the flat priority vector to the arbiter core.

Test Plan:
- Reset defaults: after release, req=16'h0005 -> gnt=16'h0001, gnt_idx=0 one cycle later (all priorities 0, rr_ptr=0). Then drop req[0] -> gnt=16'h0004 the next cycle.
- Programming: write prio[7]=9, prio[3]=5, cfg_ready pulse 1 cycle each; read back 9 and 5. req=16'h0088 -> gnt_idx=7.
- Bad config address: NUM_REQ=12, write cfg_addr=13 -> cfg_ready=1, cfg_err=1, table unchanged (read back all entries = 0).
- Round-robin: all priorities 0, req=16'h000F held, each owner drops req after 2 cycles -> grant order 0,1,2,3,0.
- Timeout: MAX_HOLD=4, prio[1]=15, prio[2]=1, req[1] held permanently and req[2] asserted -> gnt moves to idx 2 after 4 grant cycles of idx 1. With req[2] absent, idx 1 holds indefinitely.
- Async reset mid-grant: assert rst=0 between edges while gnt_valid=1 -> gnt=0 immediately. A pending config write is not committed.
